xor_reduce_pipe_mux: RTL and testbench
======================================

// Module: xor_reduce_pipe_mux
// PURPOSE
//  Pipelined, parametrised XOR (parity) reduction of a WIDTH-bit word.
//  Every 2-input XOR is a 2:1 mux cell: y = a ? ~b : b. The ^ operator is not used.
//  There is one register stage per tree level, with a valid/ready handshake on both sides.
//  Optional accumulate mode folds parity across a multi-beat packet delimited by in_last.
//  Used as the parity/checksum stage in front of serial TX and memory-check blocks.
// PARAMETERS
//  WIDTH  8  input word width, >= 1
//  ACCUM  0  0: one result per beat; 1: one result per packet, emitted on the in_last beat
// PORTS
//  clk         input   1      clock, all logic on rising edge
//  rst_n       input   1      asynchronous active-low reset
//  in_valid    input   1      input beat valid
//  in_ready    output  1      block can accept a beat this cycle
//  in_data     input   WIDTH  word to reduce
//  in_inv      input   1      1: invert result (even->odd parity); sampled per beat
//  in_last     input   1      last beat of packet (ignored when ACCUM=0)
//  out_valid   output  1      out_parity valid
//  out_ready   input   1      downstream accepts result
//  out_parity  output  1      XOR of all bits (beat or packet), optionally inverted
// BEHAVIOUR
//  - One clock domain; one reset. rst_n is asynchronous active-low.
//  - L = (WIDTH==1) ? 1 : $clog2(WIDTH) register stages.
//  - Stage k holds ceil(WIDTH/2^k) partial bits, plus valid, inv and last.
//  - An odd leftover bit at any level passes through unchanged (XOR with 0).
//  - Global advance: en = !out_valid || out_ready. in_ready = en, combinational.
//  - Transfers: in handshake = in_valid && in_ready; out handshake = out_valid && out_ready.
//  - en=0: every stage, the accumulator and the outputs hold. Nothing is dropped or duplicated.
//  - en=1: every stage shifts by one, bubbles included. Bubbles are not collapsed.
//  - ACCUM=0: a beat accepted in cycle t shows out_valid=1 in cycle t+L (no stall).
//    out_parity = (^in_data) XOR in_inv of that beat. Throughput is 1 beat/cycle.
//  - ACCUM=1: a separate accumulator register acc (reset 0) sits after the tree.
//    When a valid beat leaves the last tree level with en=1:
//      last=0: acc <= acc XOR r; no output.
//      last=1: out_parity <= acc XOR r XOR inv; out_valid <= 1; acc <= 0.
//    Here r is the beat's tree result, and inv is that last beat's in_inv.
//    in_inv on non-last beats is ignored. Latency from the last beat is the same as ACCUM=0.
//  - out_valid goes to 0 after an out handshake unless a new result is loaded in the same cycle.
//    A simultaneous handshake and new result keeps out_valid=1 with the new value.
//  - Reset (any time, including mid-packet or mid-stall):
//    all stage valids=0, acc=0, out_valid=0, out_parity=0. in_ready=1 once rst_n=1.
//    A partial packet is discarded.
//  - in_data, in_inv and in_last are don't-care when in_valid=0. They are never X-propagated into acc.
// TESTING
//  1 WIDTH=8,ACCUM=0, out_ready=1: beats 8'h00,8'h01,8'hFF,8'h80 with inv=0 at t0..t3
//    -> out_parity 0,1,0,1 at t3..t6.
//  2 WIDTH=8,ACCUM=0: 8'h03 with inv=1 -> out_parity=1. WIDTH=5: 5'b10101 -> 1.
//    WIDTH=1: in_data=1 -> 1 after 1 cycle.
//  3 Backpressure: out_ready=0 for 5 cycles with 4 beats streaming -> in_ready=0 once out_valid=1.
//    After release, all 4 results come out in order with no loss or duplicates.
//  4 ACCUM=1,WIDTH=8: beats 8'h01,8'h03,8'h01(last,inv=0) -> a single out_parity=0.
//    The same packet with last inv=1 -> 1. Non-last beats give no out_valid.
//  5 ACCUM=1: two packets back-to-back, {8'h01(last)} then {8'h00,8'h00(last)}
//    -> results 1 then 0. acc clears between packets.
//  6 Reset mid-packet: ACCUM=1, send 8'h01 (not last), assert rst_n=0 for 1 cycle,
//    then send 8'h00(last) -> result 0. All outputs are 0 during reset.

Source files
------------

// File: rtl/xor_reduce_pipe_mux_if.sv
// Handshake bundle for the pipelined parity reducer: input beat side,
// result side and the ready/valid pairs that pace both.
interface xor_reduce_pipe_mux_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;

    // Producer of beats and consumer of results
    modport master (
        output in_valid, in_data, in_inv, in_last, out_ready,
        input  in_ready, out_valid, out_parity
    );

    // The reducer itself
    modport slave (
        input  in_valid, in_data, in_inv, in_last, out_ready,
        output in_ready, out_valid, out_parity
    );
endinterface

// File: rtl/xor_reduce_pipe_mux.sv
// Pipelined XOR (parity) reduction built from 2:1 mux cells, one register
// stage per tree level, with optional per-packet accumulation. The whole
// pipe advances in lock step whenever the output register can take data.
module xor_reduce_pipe_mux #(
    parameter int WIDTH = 8,
    parameter int ACCUM = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    xor_reduce_pipe_mux_if.slave bus
);

    localparam int L = (WIDTH == 1) ? 1 : $clog2(WIDTH);

    // Two-input XOR realised as a mux: select between b and ~b on a.
    function automatic logic xor_mux(input logic a, input logic b);
        return a ? ~b : b;
    endfunction

    // Number of live partial bits at a given tree level.
    function automatic int level_cnt(input int lvl);
        return (WIDTH + (1 << lvl) - 1) >> lvl;
    endfunction

    // One tree level: pair up the n live bits; an odd leftover passes through.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] v, input int n);
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tb;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ta = v >> (2 * i);
            tb = v >> (2 * i + 1);
            if (2 * i + 1 < n) begin
                res[i] = xor_mux(ta[0], tb[0]);
            end else if (2 * i < n) begin
                res[i] = ta[0];
            end
        end
        return res;
    endfunction

    // Final level: at most two live bits remain.
    function automatic logic final_bit(input logic [WIDTH-1:0] v, input int n);
        logic [WIDTH-1:0] tb;
        tb = v >> 1;
        return (n > 1) ? xor_mux(v[0], tb[0]) : v[0];
    endfunction

    logic             en;
    logic             out_valid_q;
    logic             out_parity_q;
    logic             acc;
    logic             tree_bit;
    logic             emit;

    // Level k inputs to the tree; level 0 is the input port itself.
    logic [WIDTH-1:0] lv_d [L];
    logic [L-1:0]     lv_v;
    logic [L-1:0]     lv_i;
    logic [L-1:0]     lv_l;

    assign en            = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_parity = out_parity_q;

    assign lv_d[0] = bus.in_data;
    assign lv_v[0] = bus.in_valid;
    assign lv_i[0] = bus.in_inv;
    assign lv_l[0] = bus.in_last;

    for (genvar k = 1; k < L; k++) begin : g_stage
        logic [WIDTH-1:0] d_q;
        logic             v_q;
        logic             i_q;
        logic             l_q;

        // Stage valid: cleared on reset, shifts with the global enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (en) begin
                v_q <= lv_v[k-1];
            end
        end

        // Stage payload: one tree level of folding plus the beat's side bits.
        always_ff @(posedge clk) begin
            if (en) begin
                d_q <= fold(lv_d[k-1], level_cnt(k - 1));
                i_q <= lv_i[k-1];
                l_q <= lv_l[k-1];
            end
        end

        assign lv_d[k] = d_q;
        assign lv_v[k] = v_q;
        assign lv_i[k] = i_q;
        assign lv_l[k] = l_q;
    end

    assign tree_bit = final_bit(lv_d[L-1], level_cnt(L - 1));
    assign emit     = (ACCUM == 0) || lv_l[L-1];

    // Output register and packet accumulator: the last tree level lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= 1'b0;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
        end else if (en) begin
            if (lv_v[L-1] && emit) begin
                out_parity_q <= xor_mux(xor_mux(acc, tree_bit), lv_i[L-1]);
                out_valid_q  <= 1'b1;
                acc          <= 1'b0;
            end else begin
                out_valid_q <= 1'b0;
                if (lv_v[L-1]) begin
                    acc <= xor_mux(acc, tree_bit);
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_reduce_pipe_mux.sv
// Directed bench for xor_reduce_pipe_mux: per-beat parity at widths 8/5/1,
// streaming, backpressure, and packet accumulation including reset mid-packet.
module tb_xor_reduce_pipe_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xor_reduce_pipe_mux_if #(.WIDTH(8)) e_if ();
    xor_reduce_pipe_mux_if #(.WIDTH(5)) f_if ();
    xor_reduce_pipe_mux_if #(.WIDTH(1)) o_if ();
    xor_reduce_pipe_mux_if #(.WIDTH(8)) a_if ();

    xor_reduce_pipe_mux #(.WIDTH(8), .ACCUM(0)) u8 (.clk(clk), .rst_n(rst_n), .bus(e_if));
    xor_reduce_pipe_mux #(.WIDTH(5), .ACCUM(0)) u5 (.clk(clk), .rst_n(rst_n), .bus(f_if));
    xor_reduce_pipe_mux #(.WIDTH(1), .ACCUM(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(o_if));
    xor_reduce_pipe_mux #(.WIDTH(8), .ACCUM(1)) ua (.clk(clk), .rst_n(rst_n), .bus(a_if));

    typedef struct {
        logic [7:0] data;
        logic       inv;
        logic       e8;
        logic       e5;
        logic       e1;
    } vec_t;

    vec_t vt[10];
    int nchk = 0;
    int nerr = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ua_send(input logic [7:0] d, input logic inv, input logic last);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        a_if.in_inv   = inv;
        a_if.in_last  = last;
        step();
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
    endtask

    task automatic ua_result(input string name, input logic exp);
        step();
        chk1({name, "_early"}, a_if.out_valid, 1'b0);
        step();
        chk1({name, "_valid"}, a_if.out_valid, 1'b1);
        chk1({name, "_par"}, a_if.out_parity, exp);
        step();
        chk1({name, "_drop"}, a_if.out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] bp_d [4];
        logic       bp_e [4];
        logic [7:0] s_d  [4];
        logic       s_e  [4];
        int sent;
        int got;
        int cyc;
        logic stall_seen;

        vt[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{8'h15, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[6] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{8'h1F, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[9] = '{8'h10, 1'b1, 1'b0, 1'b0, 1'b1};

        e_if.in_valid = 0; e_if.in_data = '0; e_if.in_inv = 0; e_if.in_last = 0; e_if.out_ready = 1;
        f_if.in_valid = 0; f_if.in_data = '0; f_if.in_inv = 0; f_if.in_last = 0; f_if.out_ready = 1;
        o_if.in_valid = 0; o_if.in_data = '0; o_if.in_inv = 0; o_if.in_last = 0; o_if.out_ready = 1;
        a_if.in_valid = 0; a_if.in_data = '0; a_if.in_inv = 0; a_if.in_last = 0; a_if.out_ready = 1;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk1("rst_e_valid", e_if.out_valid, 1'b0);
        chk1("rst_a_par", a_if.out_parity, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("rst_e_in_ready", e_if.in_ready, 1'b1);
        chk1("rst_o_valid", o_if.out_valid, 1'b0);
        chk1("rst_a_valid", a_if.out_valid, 1'b0);

        // Table: one beat into the three per-beat reducers, then watch latency
        for (int i = 0; i < 10; i++) begin
            e_if.in_data = vt[i].data;
            f_if.in_data = vt[i].data[4:0];
            o_if.in_data = vt[i].data[0];
            e_if.in_inv = vt[i].inv; f_if.in_inv = vt[i].inv; o_if.in_inv = vt[i].inv;
            e_if.in_valid = 1; f_if.in_valid = 1; o_if.in_valid = 1;
            step();
            e_if.in_valid = 0; f_if.in_valid = 0; o_if.in_valid = 0;
            chk1($sformatf("w1_valid[%0d]", i), o_if.out_valid, 1'b1);
            chk1($sformatf("w1_par[%0d]", i), o_if.out_parity, vt[i].e1);
            chk1($sformatf("w8_early[%0d]", i), e_if.out_valid, 1'b0);
            step();
            chk1($sformatf("w1_drop[%0d]", i), o_if.out_valid, 1'b0);
            step();
            chk1($sformatf("w8_valid[%0d]", i), e_if.out_valid, 1'b1);
            chk1($sformatf("w8_par[%0d]", i), e_if.out_parity, vt[i].e8);
            chk1($sformatf("w5_valid[%0d]", i), f_if.out_valid, 1'b1);
            chk1($sformatf("w5_par[%0d]", i), f_if.out_parity, vt[i].e5);
            step();
            chk1($sformatf("w8_drop[%0d]", i), e_if.out_valid, 1'b0);
        end

        // Streaming at full rate: results at t3..t6 for beats at t0..t3
        s_d = '{8'h00, 8'h01, 8'hFF, 8'h80};
        s_e = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            e_if.in_valid = (i < 4);
            e_if.in_inv   = 1'b0;
            if (i < 4) e_if.in_data = s_d[i];
            step();
            if (i >= 2) begin
                chk1($sformatf("stream_valid[%0d]", i - 2), e_if.out_valid, 1'b1);
                chk1($sformatf("stream_par[%0d]", i - 2), e_if.out_parity, s_e[i - 2]);
            end
        end
        e_if.in_valid = 1'b0;
        step();
        step();

        // Backpressure: out_ready low for 5 cycles while 4 beats stream in
        bp_d = '{8'h01, 8'h03, 8'h07, 8'h0F};
        bp_e = '{1'b1, 1'b0, 1'b1, 1'b0};
        sent = 0;
        got = 0;
        cyc = 0;
        stall_seen = 1'b0;
        while (got < 4 && cyc < 40) begin
            e_if.out_ready = (cyc >= 5);
            e_if.in_valid  = (sent < 4);
            if (sent < 4) e_if.in_data = bp_d[sent];
            #1;
            if (e_if.out_valid && !e_if.out_ready && !stall_seen) begin
                chk1("bp_in_ready_low", e_if.in_ready, 1'b0);
                stall_seen = 1'b1;
            end
            if (e_if.out_valid && e_if.out_ready) begin
                if (got < 4) chk1($sformatf("bp_res[%0d]", got), e_if.out_parity, bp_e[got]);
                got++;
            end
            if (e_if.in_valid && e_if.in_ready) sent++;
            step();
            cyc++;
        end
        e_if.in_valid = 1'b0;
        e_if.out_ready = 1'b1;
        chki("bp_count", got, 4);
        chki("bp_sent", sent, 4);
        chk1("bp_stall_seen", stall_seen, 1'b1);
        #1;
        chk1("bp_no_dup", e_if.out_valid, 1'b0);
        step();
        chk1("bp_no_dup2", e_if.out_valid, 1'b0);

        // Accumulate: 01,03,01(last) -> 0; with last inv=1 -> 1
        ua_send(8'h01, 1'b0, 1'b0);
        chk1("acc_nolast0", a_if.out_valid, 1'b0);
        ua_send(8'h03, 1'b0, 1'b0);
        chk1("acc_nolast1", a_if.out_valid, 1'b0);
        ua_send(8'h01, 1'b0, 1'b1);
        ua_result("acc_pkt_inv0", 1'b0);
        ua_send(8'h01, 1'b0, 1'b0);
        ua_send(8'h03, 1'b0, 1'b0);
        ua_send(8'h01, 1'b1, 1'b1);
        ua_result("acc_pkt_inv1", 1'b1);
        // inv on non-last beats must be ignored
        ua_send(8'h01, 1'b1, 1'b0);
        ua_send(8'h03, 1'b1, 1'b0);
        ua_send(8'h01, 1'b0, 1'b1);
        ua_result("acc_pkt_midinv", 1'b0);

        // Back-to-back packets {01(last)} then {00,00(last)} -> 1 then 0
        ua_send(8'h01, 1'b0, 1'b1);
        ua_send(8'h00, 1'b0, 1'b0);
        ua_send(8'h00, 1'b0, 1'b1);
        chk1("b2b_first_valid", a_if.out_valid, 1'b1);
        chk1("b2b_first_par", a_if.out_parity, 1'b1);
        step();
        chk1("b2b_gap", a_if.out_valid, 1'b0);
        step();
        chk1("b2b_second_valid", a_if.out_valid, 1'b1);
        chk1("b2b_second_par", a_if.out_parity, 1'b0);
        step();
        chk1("b2b_drop", a_if.out_valid, 1'b0);

        // Reset mid-packet with a held result of 1 and a partial packet in flight
        a_if.out_ready = 1'b0;
        ua_send(8'h01, 1'b0, 1'b1);
        ua_send(8'h01, 1'b0, 1'b0);
        step();
        chk1("prerst_valid", a_if.out_valid, 1'b1);
        chk1("prerst_par", a_if.out_parity, 1'b1);
        chk1("prerst_in_ready", a_if.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("inrst_valid", a_if.out_valid, 1'b0);
        chk1("inrst_par", a_if.out_parity, 1'b0);
        step();
        rst_n = 1'b1;
        a_if.out_ready = 1'b1;
        #1;
        chk1("postrst_in_ready", a_if.in_ready, 1'b1);
        ua_send(8'h00, 1'b0, 1'b1);
        ua_result("postrst_pkt", 1'b0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
